des_cbc: RTL and testbench
==========================

# des_cbc

Block-chaining front end for the iterative DES core. It sits directly upstream of the core: it accepts 64-bit blocks over a valid/ready stream, applies ECB or CBC chaining, and launches one core operation per block. It then collects the core result, finishes the CBC XOR, and presents the block on an output stream. The block holds the chaining register and the key/mode snapshot, so the core sees stable inputs for the whole 16-round run.

## Interface
- TIMEOUT, 63: max cycles in WAIT before abort; 6-bit counter.
- clk  in  1  rising-edge clock, shared with core.
- reset  in  1  asynchronous, active-low; 0 = reset.
- mode_i  in  1  0 = encrypt, 1 = decrypt; sampled on input accept.
- cbc_en_i  in  1  1 = CBC, 0 = ECB; sampled on input accept.
- key_i  in  [1:64]  key; sampled on input accept.
- iv_load_i  in  1  load iv_i into chain register; honoured in IDLE only.
- iv_i  in  [1:64]  initial vector.
- in_valid  in  1  input block valid.
- in_ready  out  1  block can be accepted.
- in_data  in  [1:64]  plaintext (enc) or ciphertext (dec).
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- out_data  out  [1:64]  result block.
- core_enable  out  1  one-cycle start to core.
- core_mode  out  1  registered mode to core.
- core_key  out  [1:64]  registered key to core.
- core_data  out  [1:64]  registered block to core.
- core_result  in  [1:64]  core data output.
- core_ready  in  1  core done indication.
- busy_o  out  1  state != IDLE.
- err_o  out  1  sticky timeout flag; cleared on next accept.

## Operation
- States: IDLE, START, WAIT, OUT.
- IDLE:
  - in_ready = 1.
  - Accept on in_valid & in_ready.
  - Latch mode, cbc_en and key, and latch in_data into save_reg.
  - Load core_data, then go to START.
- Chain value used on accept = iv_i if iv_load_i is high in the same cycle, else chain_reg.
- iv_load_i in IDLE writes chain_reg even without accept. iv_load_i is ignored in other states.
- core_data on accept:
  - CBC encrypt: in_data ^ chain.
  - Otherwise: in_data.
- START: core_enable = 1 for this cycle only, then go to WAIT.
- WAIT:
  - Watchdog counts from 0.
  - If core_ready = 1, register the result into out_reg and go to OUT.
  - If the count reaches TIMEOUT, set err_o, leave chain unchanged, go to IDLE, and output nothing.
- Result processing:
  - CBC encrypt: out = core_result; chain_reg <= core_result.
  - CBC decrypt: out = core_result ^ chain_reg; chain_reg <= save_reg (the received ciphertext).
  - ECB: out = core_result; chain_reg unchanged.
- OUT:
  - out_valid = 1, and out_data holds stable.
  - On out_ready, go to IDLE.
- All XORs are bitwise over 64 bits. The [1:64] numbering is MSB-first, matching the core.
- Reset, including mid-operation:
  - State goes to IDLE.
  - All registers, chain_reg and every output are cleared to 0.
  - in_ready becomes 1 after reset is released.
  - Any in-flight core result is discarded.

## Timing
- Accept at cycle 0, core_enable high at cycle 1.
- core_ready is sampled from cycle 2 onward, so a stale ready from the previous run is never seen.
- If core_ready is high at cycle N, out_valid is high at cycle N+1.
- Minimum accept-to-output time is 3 cycles.
- One block is in flight at a time. in_ready = 0 from cycle 1 until the cycle after the output handshake.
- out_valid must not drop until out_ready. Back-to-back blocks need one IDLE cycle between them.
- A mode, key or cbc_en change while busy does not affect the current block.

## Structure
- Shared des package holds the state enum, the BLK_W = 64 constant and the mode encoding (ENC = 0, DEC = 1).
- One sub-module, des_cbc_xor: a combinational 64-bit XOR with a bypass select, used for both the pre-XOR and the post-XOR.
- The FSM, watchdog and registers stay in des_cbc.

## Test plan
- ECB encrypt with key 133457799BBCDFF1 and in_data 0123456789ABCDEF (real core): out_data = 85E813540F0AB405, and chain_reg stays 0.
- CBC encrypt with iv_load_i and iv_i = FFFFFFFFFFFFFFFF asserted together with the accept of 0123456789ABCDEF:
  - core_data = FEDCBA9876543210.
  - chain_reg ends equal to out_data.
- CBC decrypt, two blocks, using the ciphertexts from a CBC encrypt run with IV 0000000000000001:
  - Outputs reproduce the original plaintexts.
  - chain_reg ends equal to the second ciphertext.
- Backpressure: hold out_ready = 0 for 10 cycles in OUT.
  - out_valid and out_data stay stable, and in_ready = 0.
  - Transfer completes on the first out_ready.
- Stub core never raises core_ready: err_o = 1 and state is IDLE after TIMEOUT + 3 cycles from accept, and out_valid is never asserted.
- Pull reset low during WAIT:
  - All outputs are 0 asynchronously.
  - After release, in_ready = 1, and a late core_ready produces no output.

Source files
------------

// File: rtl/des_cbc_pkg.sv
// Shared definitions for the DES block-chaining front end.
// Block width, state encoding, mode encoding and watchdog limit.
package des_cbc_pkg;
  localparam int BLK_W   = 64;
  localparam int TIMEOUT = 63;
  localparam int WD_W    = 6;

  localparam logic ENC = 1'b0;
  localparam logic DEC = 1'b1;

  typedef logic [1:BLK_W] blk_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_e;
endpackage

// File: rtl/des_cbc_if.sv
// Block stream plus per-block key/mode/IV controls between source/sink and des_cbc.
interface des_cbc_if;
  import des_cbc_pkg::*;

  logic mode_i;
  logic cbc_en_i;
  blk_t key_i;
  logic iv_load_i;
  blk_t iv_i;
  logic in_valid;
  logic in_ready;
  blk_t in_data;
  logic out_valid;
  logic out_ready;
  blk_t out_data;

  modport master (
    output mode_i, cbc_en_i, key_i, iv_load_i, iv_i, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  mode_i, cbc_en_i, key_i, iv_load_i, iv_i, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/des_cbc_xor.sv
// 64-bit XOR with bypass; serves as both the CBC pre-XOR and post-XOR.
module des_cbc_xor
  import des_cbc_pkg::*;
(
  input  blk_t a,
  input  blk_t b,
  input  logic bypass,
  output blk_t y
);
  assign y = bypass ? a : (a ^ b);
endmodule

// File: rtl/des_cbc.sv
// ECB/CBC chaining front end for the iterative DES core: one block in flight,
// holds chain register and key/mode snapshot, watchdog aborts a stuck core.
module des_cbc
  import des_cbc_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  des_cbc_if.slave     bus,
  output logic         core_enable,
  output logic         core_mode,
  output blk_t         core_key,
  output blk_t         core_data,
  input  blk_t         core_result,
  input  logic         core_ready,
  output logic         busy_o,
  output logic         err_o
);
  state_e          state, state_nxt;
  blk_t            chain_reg, save_reg, out_reg;
  blk_t            chain_sel, pre_x, post_x;
  logic            cbc_q;
  logic [WD_W-1:0] wd_cnt;
  logic            accept, res_take, wd_expire;

  // Gated by reset so every output reads 0 while reset is held.
  assign bus.in_ready  = reset && (state == S_IDLE);
  assign bus.out_valid = (state == S_OUT);
  assign bus.out_data  = out_reg;

  assign accept    = bus.in_valid && bus.in_ready;
  assign res_take  = (state == S_WAIT) && core_ready;
  assign wd_expire = (state == S_WAIT) && !core_ready && (wd_cnt == WD_W'(TIMEOUT));
  assign chain_sel = bus.iv_load_i ? bus.iv_i : chain_reg;

  des_cbc_xor u_pre (
    .a      (bus.in_data),
    .b      (chain_sel),
    .bypass (!(bus.cbc_en_i && (bus.mode_i == ENC))),
    .y      (pre_x)
  );

  des_cbc_xor u_post (
    .a      (core_result),
    .b      (chain_reg),
    .bypass (!(cbc_q && (core_mode == DEC))),
    .y      (post_x)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    core_enable = 1'b0;
    busy_o      = (state != S_IDLE);
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_START;
      S_START: begin
        core_enable = 1'b1;
        state_nxt   = S_WAIT;
      end
      // core_ready wins over a simultaneous watchdog expiry
      S_WAIT: begin
        if (core_ready)     state_nxt = S_OUT;
        else if (wd_expire) state_nxt = S_IDLE;
      end
      S_OUT:   if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain_reg <= '0;
      save_reg  <= '0;
      out_reg   <= '0;
      cbc_q     <= 1'b0;
      core_mode <= 1'b0;
      core_key  <= '0;
      core_data <= '0;
      wd_cnt    <= '0;
      err_o     <= 1'b0;
    end else begin
      if ((state == S_IDLE) && bus.iv_load_i) chain_reg <= bus.iv_i;

      if (accept) begin
        core_mode <= bus.mode_i;
        cbc_q     <= bus.cbc_en_i;
        core_key  <= bus.key_i;
        core_data <= pre_x;
        save_reg  <= bus.in_data;
        err_o     <= 1'b0;
      end

      if (state == S_START)     wd_cnt <= '0;
      else if (state == S_WAIT) wd_cnt <= wd_cnt + 1'b1;

      if (wd_expire) err_o <= 1'b1;

      // Encrypt chains on the new ciphertext, decrypt on the received one.
      if (res_take) begin
        out_reg <= post_x;
        if (cbc_q) chain_reg <= (core_mode == ENC) ? core_result : save_reg;
      end
    end
  end
endmodule

// File: tb/tb_des_cbc.sv
// Randomized bench for des_cbc with a stub core (toy invertible cipher plus one DES
// known-answer pair) and a CBC reference model tracking the chain value.
module tb_des_cbc;
  import des_cbc_pkg::*;

  localparam logic [63:0] KAT_K = 64'h133457799BBCDFF1;
  localparam logic [63:0] KAT_P = 64'h0123456789ABCDEF;
  localparam logic [63:0] KAT_C = 64'h85E813540F0AB405;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  des_cbc_if sif();
  logic core_enable, core_mode, core_ready, busy_o, err_o;
  blk_t core_key, core_data, core_result;

  des_cbc dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (sif),
    .core_enable (core_enable),
    .core_mode   (core_mode),
    .core_key    (core_key),
    .core_data   (core_data),
    .core_result (core_result),
    .core_ready  (core_ready),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // DES-shaped stand-in: exact DES for the known-answer pair, otherwise a toy bijection.
  function automatic logic [63:0] cipher(input logic m, input logic [63:0] x, input logic [63:0] k);
    logic [63:0] t;
    if (k == KAT_K && m == 1'b0 && x == KAT_P) return KAT_C;
    if (k == KAT_K && m == 1'b1 && x == KAT_C) return KAT_P;
    if (m == 1'b0) begin
      t = x ^ k;
      return {t[52:0], t[63:53]} + k;
    end
    t = x - k;
    t = {t[10:0], t[63:11]};
    return t ^ k;
  endfunction

  // Stub core: ready stays high after completion until the next start (stale ready).
  int          lat_cfg = 0;
  bit          c_dead = 1'b0;
  bit          c_busy = 1'b0;
  int          c_cnt = 0;
  logic [63:0] c_x = '0, c_k = '0;
  logic        c_m = 1'b0;
  logic        rdy_r = 1'b0;
  logic [63:0] res_r = '0;
  assign core_ready  = rdy_r;
  assign core_result = res_r;

  always @(posedge clk) begin
    if (core_enable) begin
      rdy_r <= 1'b0;
      c_x <= core_data; c_k <= core_key; c_m <= core_mode;
      if (lat_cfg == 0 && !c_dead) begin
        rdy_r <= 1'b1; res_r <= cipher(core_mode, core_data, core_key); c_busy <= 1'b0;
      end else begin
        c_busy <= 1'b1; c_cnt <= lat_cfg - 1;
      end
    end else if (c_busy && !c_dead) begin
      if (c_cnt == 0) begin
        rdy_r <= 1'b1; res_r <= cipher(c_m, c_x, c_k); c_busy <= 1'b0;
      end else c_cnt <= c_cnt - 1;
    end
  end

  logic [63:0] mchain = '0;

  task automatic drive_in(input logic m, input logic cbc, input logic [63:0] k,
                          input logic [63:0] p, input logic ivl, input logic [63:0] iv);
    sif.mode_i = m; sif.cbc_en_i = cbc; sif.key_i = k; sif.in_data = p;
    sif.iv_load_i = ivl; sif.iv_i = iv; sif.in_valid = 1'b1;
    @(posedge clk); #1;
    // scramble controls while busy: the current block must not see them
    sif.in_valid = 1'b0; sif.iv_load_i = 1'b0;
    sif.mode_i = 1'($urandom); sif.cbc_en_i = 1'($urandom);
    sif.key_i = {$urandom, $urandom}; sif.in_data = {$urandom, $urandom};
    sif.iv_i = {$urandom, $urandom};
  endtask

  task automatic xfer(input logic m, input logic cbc, input logic [63:0] k, input logic [63:0] p,
                      input logic ivl, input logic [63:0] iv, input int lat, input int bp,
                      output logic [63:0] res);
    logic [63:0] ch, cd, expo;
    int n;
    ch = ivl ? iv : mchain;
    if (cbc && m == ENC) begin
      cd = p ^ ch;
      expo = cipher(ENC, cd, k);
      mchain = expo;
    end else if (cbc) begin
      cd = p;
      expo = cipher(DEC, p, k) ^ ch;
      mchain = p;
    end else begin
      cd = p;
      expo = cipher(m, p, k);
      mchain = ch;
    end
    lat_cfg = lat;
    chk("in_ready_idle", 64'(sif.in_ready), 64'd1);
    drive_in(m, cbc, k, p, ivl, iv);
    @(negedge clk);
    chk("core_en", 64'(core_enable), 64'd1);
    chk("core_data", core_data, cd);
    chk("core_key", core_key, k);
    chk("core_mode", 64'(core_mode), 64'(m));
    chk("in_ready_busy", 64'(sif.in_ready), 64'd0);
    chk("err_clr", 64'(err_o), 64'd0);
    n = 1;
    while (!sif.out_valid && n < 200) begin
      @(negedge clk); n++;
      if (n == 2) chk("core_en_pulse", 64'(core_enable), 64'd0);
    end
    chk("latency", 64'(n), 64'(lat + 3));
    chk("out_data", sif.out_data, expo);
    res = sif.out_data;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(sif.out_valid), 64'd1);
      chk("bp_data", sif.out_data, expo);
      chk("bp_in_ready", 64'(sif.in_ready), 64'd0);
    end
    sif.out_ready = 1'b1;
    @(negedge clk);
    sif.out_ready = 1'b0;
    chk("done_valid", 64'(sif.out_valid), 64'd0);
    chk("done_busy", 64'(busy_o), 64'd0);
    chk("chain", dut.chain_reg, mchain);
  endtask

  initial begin
    logic [63:0] r, c1, c2, d1, d2, p1, p2, iv;
    int idle_at;
    bit saw;
    sif.mode_i = 1'b0; sif.cbc_en_i = 1'b0; sif.key_i = '0; sif.iv_load_i = 1'b0;
    sif.iv_i = '0; sif.in_valid = 1'b0; sif.in_data = '0; sif.out_ready = 1'b0;

    #1;
    chk("rst_in_ready", 64'(sif.in_ready), 64'd0);
    chk("rst_out_valid", 64'(sif.out_valid), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1 chk("rel_in_ready", 64'(sif.in_ready), 64'd1);

    // ECB encrypt known answer
    xfer(ENC, 1'b0, KAT_K, KAT_P, 1'b0, '0, 0, 0, r);
    chk("kat_out", r, KAT_C);
    chk("kat_chain", dut.chain_reg, 64'd0);

    // CBC encrypt with IV loaded on the accept cycle
    xfer(ENC, 1'b1, KAT_K, KAT_P, 1'b1, 64'hFFFFFFFFFFFFFFFF, 2, 0, r);
    chk("cbc_chain_eq_out", dut.chain_reg, r);

    // CBC round trip, IV 1
    p1 = {$urandom, $urandom}; p2 = {$urandom, $urandom}; iv = 64'd1;
    xfer(ENC, 1'b1, KAT_K, p1, 1'b1, iv, 1, 0, c1);
    xfer(ENC, 1'b1, KAT_K, p2, 1'b0, '0, 3, 0, c2);
    xfer(DEC, 1'b1, KAT_K, c1, 1'b1, iv, 0, 1, d1);
    xfer(DEC, 1'b1, KAT_K, c2, 1'b0, '0, 4, 0, d2);
    chk("cbc_dec_p1", d1, p1);
    chk("cbc_dec_p2", d2, p2);
    chk("cbc_dec_chain", dut.chain_reg, c2);

    // Backpressure in OUT
    xfer(ENC, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, '0, 1, 10, r);

    // Random traffic, with occasional standalone IV loads in IDLE
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(4) == 0) begin
        iv = {$urandom, $urandom};
        sif.iv_load_i = 1'b1; sif.iv_i = iv;
        @(negedge clk);
        sif.iv_load_i = 1'b0;
        mchain = iv;
        chk("iv_only_chain", dut.chain_reg, mchain);
      end
      xfer(1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
           ($urandom_range(3) == 0), {$urandom, $urandom},
           int'($urandom_range(8)), int'($urandom_range(3)), r);
    end

    // Watchdog: core never answers
    c_dead = 1'b1; lat_cfg = 5;
    drive_in(ENC, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, '0);
    idle_at = 0; saw = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (sif.out_valid) saw = 1'b1;
      if (!busy_o && idle_at == 0) idle_at = n;
    end
    chk("to_cycles", 64'(idle_at), 64'(TIMEOUT + 3));
    chk("to_err", 64'(err_o), 64'd1);
    chk("to_no_valid", 64'(saw), 64'd0);
    chk("to_chain", dut.chain_reg, mchain);
    c_dead = 1'b0;
    xfer(DEC, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, '0, 2, 0, r);

    // Reset while WAITing on a slow core
    lat_cfg = 30;
    drive_in(ENC, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, {$urandom, $urandom});
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 64'(busy_o), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_in_ready", 64'(sif.in_ready), 64'd0);
    chk("arst_out_valid", 64'(sif.out_valid), 64'd0);
    chk("arst_out_data", sif.out_data, 64'd0);
    chk("arst_core_en", 64'(core_enable), 64'd0);
    chk("arst_core_mode", 64'(core_mode), 64'd0);
    chk("arst_core_key", core_key, 64'd0);
    chk("arst_core_data", core_data, 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_err", 64'(err_o), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mchain = '0;
    #1;
    chk("rel2_in_ready", 64'(sif.in_ready), 64'd1);
    chk("rel2_chain", dut.chain_reg, mchain);
    saw = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (sif.out_valid) saw = 1'b1;
    end
    chk("late_ready_dropped", 64'(saw), 64'd0);
    xfer(ENC, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, '0, 0, 2, r);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
